// File: rtl/i2s_master_tx_pkg.sv
// Shared audio constants for the I2S blocks: default widths, clock division and the slot layout.
package i2s_master_tx_pkg;

  localparam int BITSIZE_DEF  = 16;
  localparam int SLOTBITS_DEF = 32;
  localparam int CLKDIV_DEF   = 8;

  // LRCLK level names the slot being transmitted.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  function automatic int frame_bits(input int slotbits);
    return 2 * slotbits;
  endfunction

endpackage

// File: rtl/i2s_master_tx_clkgen.sv
// Master-mode clock generator: divides osc into MCLK (osc/4) and BCLK, and flags the BCLK falling-edge cycle.
module i2s_master_tx_clkgen
  import i2s_master_tx_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic osc,
  input  logic rst,
  output logic mclk,
  output logic bclk,
  output logic tick_fall
);

  localparam int PERIOD = 2 * CLKDIV;
  localparam int DW     = $clog2(PERIOD);
  localparam logic [DW-1:0] DIV_LAST = DW'(PERIOD - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge osc) begin
    if (rst) begin
      div  <= '0;
      mclk <= 1'b0;
      bclk <= 1'b0;
    end else begin
      div  <= div_next;
      mclk <= div_next[1];
      if (div_next == DIV_HALF) begin
        bclk <= 1'b1;
      end else if (div_next == '0) begin
        bclk <= 1'b0;
      end
    end
  end

  // Registered outputs toggle on the edge that ends this cycle, so bclk falls together with the frame logic.
  assign tick_fall = (div == DIV_LAST);

endmodule

// File: rtl/i2s_master_tx.sv
// Clock-master I2S transmitter: one-entry sample buffer feeding a frame shifter with standard one-BCLK data delay.
module i2s_master_tx
  import i2s_master_tx_pkg::*;
#(
  parameter int BITSIZE  = BITSIZE_DEF,
  parameter int SLOTBITS = SLOTBITS_DEF,
  parameter int CLKDIV   = CLKDIV_DEF
) (
  input  logic               osc,
  input  logic               rst,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mclk,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun
);

  localparam int FRAME_BITS = frame_bits(SLOTBITS);
  localparam int CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] K_LAST  = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] K_RIGHT = CW'(SLOTBITS);

  logic                  tick_fall;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         k;
  logic                  load;
  logic                  accept;
  logic                  full;
  logic [BITSIZE-1:0]    held_left;
  logic [BITSIZE-1:0]    held_right;
  logic [FRAME_BITS-1:0] word;
  logic [FRAME_BITS-1:0] shift;

  i2s_master_tx_clkgen #(
    .CLKDIV(CLKDIV)
  ) u_clkgen (
    .osc      (osc),
    .rst      (rst),
    .mclk     (mclk),
    .bclk     (bclk),
    .tick_fall(tick_fall)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    k      = (bit_cnt == K_LAST) ? '0 : bit_cnt + 1'b1;
    load   = tick_fall && (k == '0);
    accept = in_valid && in_ready;
    word   = '0;
    if (full) begin
      // Each sample starts one bit after its LRCLK edge.
      word[FRAME_BITS-2 -: BITSIZE] = held_left;
      word[SLOTBITS-2   -: BITSIZE] = held_right;
    end
  end

  // NOTE: sample storage has no reset; the full flag alone decides whether its contents are used.
  always_ff @(posedge osc) begin
    if (accept) begin
      held_left  <= left_in;
      held_right <= right_in;
    end
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      bit_cnt     <= K_LAST;
      shift       <= '0;
      sdata       <= 1'b0;
      lrclk       <= SLOT_RIGHT;
      full        <= 1'b0;
      in_ready    <= 1'b1;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (tick_fall) begin
        bit_cnt <= k;
        lrclk   <= (k >= K_RIGHT) ? SLOT_RIGHT : SLOT_LEFT;
        if (load) begin
          sdata       <= word[FRAME_BITS-1];
          shift       <= word << 1;
          frame_start <= 1'b1;
          underrun    <= !full;
        end else begin
          sdata <= shift[FRAME_BITS-1];
          shift <= shift << 1;
        end
      end
      // A load drains the buffer using pre-edge contents; a same-cycle accept refills it.
      full     <= accept || (full && !load);
      in_ready <= !(accept || (full && !load));
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx: cycle-indexed reference model plus literal timing and frame checks.
module tb_i2s_master_tx;

  localparam int BITSIZE    = 16;
  localparam int SLOTBITS   = 32;
  localparam int CLKDIV     = 8;
  localparam int BCLK_P     = 2 * CLKDIV;
  localparam int FRAME_BITS = 2 * SLOTBITS;
  localparam int LR_P       = FRAME_BITS * BCLK_P;

  logic        osc = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mclk, bclk, lrclk, sdata, frame_start, underrun;

  always #5 osc = ~osc;

  i2s_master_tx #(
    .BITSIZE (BITSIZE),
    .SLOTBITS(SLOTBITS),
    .CLKDIV  (CLKDIV)
  ) dut (
    .osc        (osc),
    .rst        (rst),
    .left_in    (left_in),
    .right_in   (right_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mclk       (mclk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: everything is a function of n, the osc edges since reset release.
  int          n = 0;
  bit          model_live = 0;
  bit          full_m = 0;
  bit          exp_fs = 0;
  bit          exp_ur = 0;
  bit          m_load, m_acc;
  logic [15:0] hl = '0;
  logic [15:0] hr = '0;
  logic [63:0] cur = '0;
  int          kc;

  function automatic logic [63:0] word_of(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] wl, wr;
    wl = 64'(l);
    wr = 64'(r);
    return (wl << (FRAME_BITS - 1 - BITSIZE)) | (wr << (SLOTBITS - 1 - BITSIZE));
  endfunction

  function automatic int k_of(input int cyc);
    return (cyc < BCLK_P) ? FRAME_BITS - 1 : ((cyc / BCLK_P) - 1) % FRAME_BITS;
  endfunction

  initial forever begin
    @(posedge osc);
    if (rst) begin
      n = 0; full_m = 0; cur = '0; exp_fs = 0; exp_ur = 0; model_live = 1;
    end else begin
      n++;
      m_load = (n % LR_P) == BCLK_P;
      m_acc  = in_valid && !full_m;
      exp_fs = m_load;
      exp_ur = m_load && !full_m;
      if (m_load) begin
        cur    = full_m ? word_of(hl, hr) : '0;
        full_m = 0;
      end
      if (m_acc) begin
        hl = left_in; hr = right_in; full_m = 1;
      end
    end
  end

  initial forever begin
    @(negedge osc);
    if (model_live) begin
      kc = k_of(n);
      check("bclk",        64'(bclk),        64'((n % BCLK_P) >= CLKDIV));
      check("mclk",        64'(mclk),        64'(((n % BCLK_P) / 2) % 2));
      check("lrclk",       64'(lrclk),       64'(kc >= SLOTBITS));
      check("sdata",       64'(sdata),       64'(cur[FRAME_BITS-1-kc]));
      check("in_ready",    64'(in_ready),    64'(!full_m));
      check("frame_start", 64'(frame_start), 64'(exp_fs));
      check("underrun",    64'(underrun),    64'(exp_ur));
    end
  end

  task automatic tick();
    @(posedge osc);
    #2;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int b = 0;
    while (!in_ready && b < 4 * LR_P) begin tick(); b++; end
    check("push_ready", 64'(in_ready), 64'd1);
    left_in = l; right_in = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_start(output int waited);
    waited = 0;
    do begin tick(); waited++; end while (!frame_start && waited < 2 * LR_P);
    check("frame_start_seen", 64'(frame_start), 64'd1);
  endtask

  task automatic wait_n_mod(input int target);
    int b = 0;
    while ((n % LR_P) != target && b < 2 * LR_P) begin tick(); b++; end
    check("phase_reached", 64'(n % LR_P), 64'(target));
  endtask

  int          rise, fs, w, cnt, urc, lr_r1, lr_r2, lr_f, bp1, bp2;
  logic        urf, pb, plr;
  logic [63:0] bits;

  initial begin
    repeat (3) tick();
    check("rst_bclk",     64'(bclk),        64'd0);
    check("rst_lrclk",    64'(lrclk),       64'd1);
    check("rst_sdata",    64'(sdata),       64'd0);
    check("rst_mclk",     64'(mclk),        64'd0);
    check("rst_in_ready", 64'(in_ready),    64'd1);
    check("rst_fs",       64'(frame_start), 64'd0);
    check("model_word_pin", word_of(16'hA5C3, 16'h8001), 64'h52E1_8000_4000_8000);
    rst = 1'b0;

    rise = -1; fs = -1; urf = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bclk && rise < 0) rise = c;
      if (frame_start && fs < 0) begin fs = c; urf = underrun; end
    end
    check("first_bclk_rise",   64'(rise), 64'd8);
    check("first_frame_start", 64'(fs),   64'd16);
    check("first_underrun",    64'(urf),  64'd1);

    // Known pair, then a held valid that must be ignored while full.
    push(16'hA5C3, 16'h8001);
    check("ready_low_after_accept", 64'(in_ready), 64'd0);
    left_in = 16'hFFFF; right_in = 16'hFFFF; in_valid = 1'b1;
    repeat (40) tick();
    in_valid = 1'b0;
    check("ready_low_while_full", 64'(in_ready), 64'd0);
    wait_frame_start(w);
    check("loaded_no_underrun", 64'(underrun), 64'd0);
    check("ready_after_load",   64'(in_ready), 64'd1);
    bits = '0; cnt = 0; w = 0; pb = bclk;
    while (cnt < FRAME_BITS && w < 2 * LR_P) begin
      tick(); w++;
      if (bclk && !pb) begin bits[63-cnt] = sdata; cnt++; end
      pb = bclk;
    end
    check("frame_bits_a5c3_8001", bits, 64'h52E1_8000_4000_8000);

    // Valid raised exactly in the load cycle on an empty buffer.
    wait_n_mod(BCLK_P - 1);
    left_in = 16'h1234; right_in = 16'hFEDC; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("late_valid_underrun", 64'(underrun),    64'd1);
    check("late_valid_fs",       64'(frame_start), 64'd1);
    check("late_valid_held",     64'(in_ready),    64'd0);
    wait_frame_start(w);
    check("late_sample_no_underrun", 64'(underrun), 64'd0);

    // Three idle frames: timing of lrclk/bclk and underrun cadence.
    urc = 0; lr_r1 = -1; lr_r2 = -1; lr_f = -1; bp1 = -1; bp2 = -1;
    pb = bclk; plr = lrclk;
    for (int c = 1; c <= 3 * LR_P; c++) begin
      tick();
      if (underrun) urc++;
      if (lrclk != plr) begin
        check("lrclk_on_bclk_fall", {62'd0, pb, bclk}, 64'd2);
        if (lrclk) begin
          if (lr_r1 < 0) lr_r1 = c;
          else if (lr_r2 < 0) lr_r2 = c;
        end else if (lr_r1 >= 0 && lr_f < 0) begin
          lr_f = c;
        end
      end
      if (bclk && !pb) begin
        if (bp1 < 0) bp1 = c;
        else if (bp2 < 0) bp2 = c;
      end
      pb = bclk; plr = lrclk;
    end
    check("idle_underruns", 64'(urc),           64'd3);
    check("lrclk_period",   64'(lr_r2 - lr_r1), 64'(LR_P));
    check("lrclk_high",     64'(lr_f - lr_r1),  64'(LR_P / 2));
    check("bclk_period",    64'(bp2 - bp1),     64'(BCLK_P));

    // Random traffic with random gaps, checked by the model every cycle.
    for (int i = 0; i < 12; i++) begin
      push(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 1500)) tick();
    end

    // Reset mid-frame with a sample held.
    wait_frame_start(w);
    push(16'h7E57, 16'hC0DE);
    check("held_before_reset", 64'(in_ready), 64'd0);
    wait_n_mod(BCLK_P + 20 * BCLK_P);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_bclk",     64'(bclk),     64'd0);
    check("mid_rst_lrclk",    64'(lrclk),    64'd1);
    check("mid_rst_sdata",    64'(sdata),    64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    wait_frame_start(w);
    check("post_rst_load_cycle", 64'(w),        64'd16);
    check("post_rst_underrun",   64'(underrun), 64'd1);
    repeat (LR_P + 64) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
